// File: rtl/unlock_sequencer.sv
// Lock/unlock sequencer for the 4-digit safe: entry buffer, password store, failure count and lockout.
// Optional idle auto-relock from OPEN/SET_PW is built when UNLOCK_AUTO_RELOCK_EN is defined.
module unlock_sequencer #(
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 250_000_000,
    parameter int          RELOCK_CYCLES  = 1_500_000_000,
    parameter logic [15:0] DEFAULT_PW     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        open_close,
    input  logic        reset_password,
    input  logic        confirm_new_password,
    input  logic        clean_password,
    output logic [15:0] entry,
    output logic [2:0]  entry_cnt,
    output logic        opened,
    output logic        graph_type,
    output logic        show_digits,
    output logic        alarm,
    output logic [2:0]  fail_cnt
);

    localparam int          LOCK_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]  FAIL_LIM  = 3'(MAX_FAIL);

    typedef enum logic [1:0] {LOCKED, OPEN, SET_PW, LOCKOUT} state_t;

    state_t            state, state_next;
    logic [15:0]       pw, pw_next;
    logic [15:0]       entry_next;
    logic [2:0]        entry_cnt_next, fail_cnt_next, fail_inc;
    logic              opened_next, graph_type_next, show_digits_next, alarm_next;
    logic [LOCK_W-1:0] lock_timer, lock_timer_next;

    // Only the highest-priority event present in a cycle is allowed to act.
    logic oc_ev, cnp_ev, rp_ev, cp_ev, key_ev, digit_ok;

    assign oc_ev    = open_close;
    assign cnp_ev   = confirm_new_password & ~open_close;
    assign rp_ev    = reset_password & ~open_close & ~confirm_new_password;
    assign cp_ev    = clean_password & ~open_close & ~confirm_new_password & ~reset_password;
    assign key_ev   = key_valid & ~open_close & ~confirm_new_password & ~reset_password
                      & ~clean_password;
    assign digit_ok = key_ev && (key_code <= 4'd9) && (entry_cnt < 3'd4);
    assign fail_inc = fail_cnt + 3'd1;

`ifdef UNLOCK_AUTO_RELOCK_EN
    localparam int          RELOCK_W    = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
    localparam logic [RELOCK_W-1:0] RELOCK_LOAD = RELOCK_W'(RELOCK_CYCLES - 1);

    logic [RELOCK_W-1:0] relock_timer, relock_timer_next;
    logic                any_pulse;

    assign any_pulse = key_valid | open_close | reset_password | confirm_new_password
                       | clean_password;
`endif

    always_comb begin
        state_next       = state;
        pw_next          = pw;
        entry_next       = entry;
        entry_cnt_next   = entry_cnt;
        fail_cnt_next    = fail_cnt;
        opened_next      = opened;
        graph_type_next  = graph_type;
        show_digits_next = show_digits;
        alarm_next       = alarm;
        lock_timer_next  = lock_timer;

        case (state)
            LOCKED: begin
                if (oc_ev) begin
                    entry_next     = 16'h0000;
                    entry_cnt_next = 3'd0;
                    if (entry_cnt == 3'd4 && entry == pw) begin
                        state_next      = OPEN;
                        opened_next     = 1'b1;
                        graph_type_next = 1'b1;
                        fail_cnt_next   = 3'd0;
                    end else begin
                        fail_cnt_next = fail_inc;
                        if (fail_inc == FAIL_LIM) begin
                            state_next      = LOCKOUT;
                            alarm_next      = 1'b1;
                            lock_timer_next = LOCK_LOAD;
                        end
                    end
                end else if (cp_ev) begin
                    entry_next     = 16'h0000;
                    entry_cnt_next = 3'd0;
                end else if (digit_ok) begin
                    entry_next     = {entry[11:0], key_code};
                    entry_cnt_next = entry_cnt + 3'd1;
                end
            end
            OPEN: begin
                if (oc_ev) begin
                    state_next      = LOCKED;
                    opened_next     = 1'b0;
                    graph_type_next = 1'b0;
                    entry_next      = 16'h0000;
                    entry_cnt_next  = 3'd0;
                end else if (rp_ev) begin
                    state_next       = SET_PW;
                    show_digits_next = 1'b1;
                    entry_next       = 16'h0000;
                    entry_cnt_next   = 3'd0;
                end else if (cp_ev) begin
                    pw_next        = 16'h0000;
                    entry_next     = 16'h0000;
                    entry_cnt_next = 3'd0;
                end
            end
            SET_PW: begin
                if (oc_ev) begin
                    state_next       = LOCKED;
                    show_digits_next = 1'b0;
                    opened_next      = 1'b0;
                    graph_type_next  = 1'b0;
                    entry_next       = 16'h0000;
                    entry_cnt_next   = 3'd0;
                end else if (cnp_ev) begin
                    if (entry_cnt == 3'd4) pw_next = entry;
                    state_next       = OPEN;
                    show_digits_next = 1'b0;
                    entry_next       = 16'h0000;
                    entry_cnt_next   = 3'd0;
                end else if (cp_ev) begin
                    entry_next     = 16'h0000;
                    entry_cnt_next = 3'd0;
                end else if (digit_ok) begin
                    entry_next     = {entry[11:0], key_code};
                    entry_cnt_next = entry_cnt + 3'd1;
                end
            end
            LOCKOUT: begin
                if (lock_timer == '0) begin
                    state_next    = LOCKED;
                    alarm_next    = 1'b0;
                    fail_cnt_next = 3'd0;
                end else begin
                    lock_timer_next = lock_timer - 1'b1;
                end
            end
            default: state_next = LOCKED;
        endcase

`ifdef UNLOCK_AUTO_RELOCK_EN
        // Idle cycles carry no event, so the timeout never collides with a button action.
        relock_timer_next = RELOCK_LOAD;
        if ((state == OPEN || state == SET_PW) && !any_pulse) begin
            if (relock_timer == '0) begin
                state_next       = LOCKED;
                opened_next      = 1'b0;
                graph_type_next  = 1'b0;
                show_digits_next = 1'b0;
                entry_next       = 16'h0000;
                entry_cnt_next   = 3'd0;
            end else begin
                relock_timer_next = relock_timer - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= LOCKED;
            pw          <= DEFAULT_PW;
            entry       <= 16'h0000;
            entry_cnt   <= 3'd0;
            fail_cnt    <= 3'd0;
            opened      <= 1'b0;
            graph_type  <= 1'b0;
            show_digits <= 1'b0;
            alarm       <= 1'b0;
            lock_timer  <= '0;
        end else begin
            state       <= state_next;
            pw          <= pw_next;
            entry       <= entry_next;
            entry_cnt   <= entry_cnt_next;
            fail_cnt    <= fail_cnt_next;
            opened      <= opened_next;
            graph_type  <= graph_type_next;
            show_digits <= show_digits_next;
            alarm       <= alarm_next;
            lock_timer  <= lock_timer_next;
        end
    end

`ifdef UNLOCK_AUTO_RELOCK_EN
    always_ff @(posedge clk) begin
        if (!rst) relock_timer <= RELOCK_LOAD;
        else      relock_timer <= relock_timer_next;
    end
`endif

endmodule

// File: tb/tb_unlock_sequencer.sv
// Scoreboard bench for unlock_sequencer: a digit-queue reference model predicts every cycle's outputs.
// Directed scenarios first, then randomized events with collisions and occasional resets.
module tb_unlock_sequencer;

    localparam int          MAXF = 3;
    localparam int          LOCKC = 20;
    localparam int          RELC = 50;
    localparam logic [15:0] DPW = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, key_valid, open_close, reset_password, confirm_new_password, clean_password;
    logic [3:0]  key_code;
    logic [15:0] entry;
    logic [2:0]  entry_cnt, fail_cnt;
    logic        opened, graph_type, show_digits, alarm;

    always #5 clk = ~clk;

    unlock_sequencer #(
        .MAX_FAIL(MAXF), .LOCKOUT_CYCLES(LOCKC), .RELOCK_CYCLES(RELC), .DEFAULT_PW(DPW)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .open_close(open_close), .reset_password(reset_password),
        .confirm_new_password(confirm_new_password), .clean_password(clean_password),
        .entry(entry), .entry_cnt(entry_cnt), .opened(opened), .graph_type(graph_type),
        .show_digits(show_digits), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    typedef struct packed {
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic        opened;
        logic        graph;
        logic        show;
        logic        alarm;
        logic [2:0]  fail;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: entered digits as a list, the lock as a few flags and countdowns.
    int m_digits[$];
    int m_pw;
    bit m_unlocked, m_setting;
    int m_lock_left, m_fail, m_idle;

    function automatic int entry_val();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.entry  = 16'(entry_val());
        o.cnt    = 3'(m_digits.size());
        o.opened = m_unlocked;
        o.graph  = m_unlocked;
        o.show   = m_setting;
        o.alarm  = (m_lock_left > 0);
        o.fail   = 3'(m_fail);
        return o;
    endfunction

    task automatic model_step(input bit r, input bit kv, input int kc, input bit oc,
                              input bit cnp, input bit rp, input bit cp);
        bit was_active, any, digit;
        if (!r) begin
            m_digits.delete();
            m_pw = DPW; m_unlocked = 0; m_setting = 0;
            m_lock_left = 0; m_fail = 0; m_idle = 0;
            return;
        end
        was_active = m_unlocked;
        any   = kv | oc | cnp | rp | cp;
        digit = kv && !oc && !cnp && !rp && !cp && kc <= 9 && m_digits.size() < 4;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fail = 0;
        end else if (!m_unlocked) begin
            if (oc) begin
                if (m_digits.size() == 4 && entry_val() == m_pw) begin
                    m_unlocked = 1; m_fail = 0;
                end else begin
                    m_fail++;
                    if (m_fail == MAXF) m_lock_left = LOCKC;
                end
                m_digits.delete();
            end else if (cnp || rp) begin
            end else if (cp) m_digits.delete();
            else if (digit) m_digits.push_back(kc);
        end else if (m_setting) begin
            if (oc) begin
                m_setting = 0; m_unlocked = 0; m_digits.delete();
            end else if (cnp) begin
                if (m_digits.size() == 4) m_pw = entry_val();
                m_setting = 0; m_digits.delete();
            end else if (rp) begin
            end else if (cp) m_digits.delete();
            else if (digit) m_digits.push_back(kc);
        end else begin
            if (oc) begin
                m_unlocked = 0; m_digits.delete();
            end else if (cnp) begin
            end else if (rp) begin
                m_setting = 1; m_digits.delete();
            end else if (cp) begin
                m_pw = 0; m_digits.delete();
            end
        end
`ifdef UNLOCK_AUTO_RELOCK_EN
        if (was_active && !any) begin
            m_idle++;
            if (m_idle == RELC) begin
                m_unlocked = 0; m_setting = 0; m_digits.delete(); m_idle = 0;
            end
        end else m_idle = 0;
`else
        m_idle = (was_active && !any) ? m_idle + 1 : 0;
`endif
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, queue them for the monitor.
    task automatic cycle(input bit r, input bit kv, input int kc, input bit oc,
                         input bit cnp, input bit rp, input bit cp);
        obs_t e;
        rst = r; key_valid = kv; key_code = 4'(kc); open_close = oc;
        confirm_new_password = cnp; reset_password = rp; clean_password = cp;
        model_step(r, kv, kc, oc, cnp, rp, cp);
        e = model_obs();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic key(input int kc);
        cycle(1, 1, kc, 0, 0, 0, 0);
    endtask

    task automatic keys4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic press_oc();
        cycle(1, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {entry, entry_cnt, opened, graph_type, show_digits, alarm, fail_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard @%0t: got entry=%h cnt=%0d open=%b graph=%b show=%b alarm=%b fail=%0d, expected entry=%h cnt=%0d open=%b graph=%b show=%b alarm=%b fail=%0d",
                         $time, a.entry, a.cnt, a.opened, a.graph, a.show, a.alarm, a.fail,
                         e.entry, e.cnt, e.opened, e.graph, e.show, e.alarm, e.fail);
            end
        end
    end

    initial begin
        int n, r, kc, wait_cnt;
        bit kv, oc, cnp, rp, cp, rr;

        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("reset_opened", opened, 0);

        // Default password opens the lock.
        keys4(0, 0, 0, 0);
        press_oc();
        check("open_default", opened, 1);
        check("open_graph", graph_type, 1);
        check("open_entry_cnt", entry_cnt, 0);

        // Change password to 1234, close, reopen with it, then a wrong code.
        cycle(1, 0, 0, 0, 0, 1, 0);
        check("setpw_show", show_digits, 1);
        keys4(1, 2, 3, 4);
        cycle(1, 0, 0, 0, 1, 0, 0);
        press_oc();
        check("closed", opened, 0);
        keys4(1, 2, 3, 4);
        press_oc();
        check("reopen_new_pw", opened, 1);
        press_oc();
        keys4(0, 0, 0, 0);
        press_oc();
        check("wrong_fail1", fail_cnt, 1);

        // Two more failures trigger lockout; a correct code during it is ignored.
        keys4(9, 9, 9, 9);
        press_oc();
        keys4(9, 9, 9, 9);
        press_oc();
        check("lockout_alarm", alarm, 1);
        n = 0;
        while (alarm && n < 100) begin
            n++;
            if (n <= 4) key(n);
            else if (n == 5) press_oc();
            else idle(1);
        end
        check("lockout_len", n, LOCKC);
        check("after_lockout_fail", fail_cnt, 0);
        check("after_lockout_opened", opened, 0);

        // Overflow digits and a non-digit key.
        keys4(1, 2, 3, 4);
        key(5);
        key(10);
        check("entry_full", entry, 16'h1234);
        check("entry_cnt_full", entry_cnt, 4);
        cycle(1, 0, 0, 0, 0, 0, 1);
        check("clean_entry", entry_cnt, 0);

        // open_close together with a key: compare uses the pre-edge entry.
        keys4(1, 2, 3, 4);
        cycle(1, 1, 7, 1, 0, 0, 0);
        check("collide_open", opened, 1);
        check("collide_cnt", entry_cnt, 0);

`ifdef UNLOCK_AUTO_RELOCK_EN
        idle(RELC - 1);
        key(3);
        idle(RELC - 1);
        check("relock_reload", opened, 1);
        idle(1);
        check("relock_fire", opened, 0);
`else
        idle(RELC + 10);
        check("no_relock", opened, 1);
        press_oc();
`endif

        // Randomized traffic with collisions and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            kv = 0; oc = 0; cnp = 0; rp = 0; cp = 0; rr = 1; kc = 0;
            if (r < 35) begin
                kv = 1;
                if ($urandom_range(0, 9) < 7 && m_digits.size() < 4)
                    kc = (m_pw >> (12 - 4 * m_digits.size())) & 15;
                else
                    kc = $urandom_range(0, 15);
            end else if (r < 41) oc = 1;
            else if (r < 45) rp = 1;
            else if (r < 49) cnp = 1;
            else if (r < 52) cp = 1;
            else if (r < 53) rr = 0;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: oc = 1;
                    1: cnp = 1;
                    2: rp = 1;
                    default: cp = 1;
                endcase
            end
            cycle(rr, kv, kc, oc, cnp, rp, cp);
        end

        idle(2);
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unlock_sequencer.md
# unlock_sequencer

Central sequencing FSM for the 4-digit safe box. It takes one-cycle key events from the keypad scanner and the debounced button pulses, and manages the entry buffer and the stored password. It decides lock/unlock, counts failed attempts and enforces a lockout window with the alarm raised. Outputs feed the graph display, alarm driver and password display blocks directly.

## Interface

Parameters:
- `MAX_FAIL`, 3: consecutive wrong attempts that trigger lockout (1..7).
- `LOCKOUT_CYCLES`, 250_000_000: clk cycles spent in LOCKOUT (5 s at 50 MHz).
- `RELOCK_CYCLES`, 1_500_000_000: idle cycles in OPEN before auto-relock. Used only with `UNLOCK_AUTO_RELOCK_EN`.
- `DEFAULT_PW`, 16'h0000: password loaded at reset, four BCD nibbles, digit 3 in the MSBs.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-low reset.
- `key_valid` in 1: one-cycle pulse, a keypad key was pressed.
- `key_code` in 4: key value, valid with `key_valid`.
- `open_close` in 1: one-cycle debounced pulse.
- `reset_password` in 1: one-cycle debounced pulse.
- `confirm_new_password` in 1: one-cycle debounced pulse.
- `clean_password` in 1: one-cycle debounced pulse.
- `entry` out 16: entry buffer, newest digit in [3:0].
- `entry_cnt` out 3: number of digits entered, 0..4.
- `opened` out 1: lock is open.
- `graph_type` out 1: 1 shows the open graphic, 0 shows the closed graphic.
- `show_digits` out 1: 1 shows digits, 0 shows dashes.
- `alarm` out 1: drives the alarm LED and buzzer.
- `fail_cnt` out 3: consecutive failed attempts.

## Operation

States: LOCKED, OPEN, SET_PW, LOCKOUT. All outputs are registered.

Reset values:
- State LOCKED, password `DEFAULT_PW`.
- `entry` 0, `entry_cnt` 0, `fail_cnt` 0.
- `opened`, `graph_type`, `show_digits` and `alarm` all 0.

Digit entry, in LOCKED and SET_PW only:
- A `key_valid` with `key_code` ≤ 9 and `entry_cnt` < 4 does `entry <= {entry[11:0], key_code}` and increments `entry_cnt`.
- Codes A–F are ignored.
- Digits arriving when `entry_cnt` = 4 are dropped.
- In OPEN and LOCKOUT all keys are ignored.

LOCKED:
- `open_close` with `entry_cnt` = 4 and `entry` = password: go to OPEN, set `opened` = 1 and `graph_type` = 1, clear `fail_cnt`.
- Otherwise `open_close` counts as a failure, including a short entry: `fail_cnt` increments.
  - If the new count equals `MAX_FAIL`, go to LOCKOUT, set `alarm` = 1 and load the lockout timer.
- Every `open_close` clears the entry (`entry`, `entry_cnt` = 0).
- `clean_password` clears the entry only.

OPEN:
- `open_close`: go to LOCKED, drop `opened` and `graph_type`, clear the entry.
- `reset_password`: go to SET_PW, set `show_digits` = 1, clear the entry.
- `clean_password`: load 16'h0000 as the password and clear the entry. State stays OPEN.

SET_PW:
- `confirm_new_password` with `entry_cnt` = 4: the password takes `entry`. Go to OPEN, `show_digits` = 0, clear the entry.
- `confirm_new_password` with `entry_cnt` < 4: the password is unchanged. Go to OPEN, `show_digits` = 0, clear the entry.
- `open_close`: abort. Go to LOCKED, `show_digits` = 0, `opened` = 0, password unchanged.
- `clean_password`: clear the entry, stay in SET_PW.

LOCKOUT:
- The timer counts down from `LOCKOUT_CYCLES`-1. At 0: go to LOCKED, `alarm` = 0, `fail_cnt` = 0.
- All buttons are ignored.

Simultaneous events, in priority order: `open_close` > `confirm_new_password` > `reset_password` > `clean_password` > `key_valid`. Only the highest-priority event present in a cycle acts.

## Timing

- Event sampled at edge N: state and outputs change at edge N+1 (one-cycle latency).
- A digit and `open_close` arriving in the same cycle: the digit is discarded and the compare uses the pre-edge `entry`.
- Lockout lasts exactly `LOCKOUT_CYCLES` cycles of `alarm` = 1, then LOCKED.
- Timer widths are sized with `$clog2(parameter)` and never wrap.
- Asserting `rst` mid-operation, including in LOCKOUT: all registers reach their reset values at the next edge and the password reverts to `DEFAULT_PW`.

## Configuration

`UNLOCK_AUTO_RELOCK_EN`
- Defined:
  - In OPEN, an idle counter reloads on any input pulse.
  - After `RELOCK_CYCLES` idle cycles the block goes to LOCKED, as if `open_close` had been pressed.
  - In SET_PW the same timeout aborts to LOCKED with the password unchanged.
- Undefined: no idle counter is built, and OPEN and SET_PW persist indefinitely.

## Test plan

- Reset, enter keys 0,0,0,0, pulse `open_close` → `opened` = 1 and `graph_type` = 1 one cycle later, `entry_cnt` = 0.
- From OPEN: `reset_password`, keys 1,2,3,4, `confirm_new_password`, `open_close`; then keys 1,2,3,4, `open_close` → reopens. Entering 0,0,0,0 instead → `fail_cnt` = 1.
- Three wrong attempts with 9,9,9,9 (`LOCKOUT_CYCLES` = 20) → `alarm` = 1 for exactly 20 cycles. A correct code entered meanwhile is ignored. Afterwards `fail_cnt` = 0 and the block is LOCKED.
- Keys 1,2,3,4,5 and key A → `entry` = 16'h1234, `entry_cnt` = 4. `clean_password` → `entry_cnt` = 0.
- `open_close` and `key_valid` in the same cycle, with `entry` already correct → unlocks, and the key is not stored.
- With `UNLOCK_AUTO_RELOCK_EN` and `RELOCK_CYCLES` = 50: open, then idle 50 cycles → `opened` = 0. Idle 49 cycles then a key pulse → the counter reloads and the block stays OPEN.
